uart_escape_decoder: RTL and testbench
======================================

# uart_escape_decoder

Parametrised in-band command decoder between the UART receiver and the VGA text pipeline. It splits the received byte stream into two outputs: display data, which is forwarded, and escape sequences, which write a bank of configuration registers (for example rows and columns). Compared with the fixed two-register escape logic, it adds an addressable register bank, multi-byte values, an escaped literal ESC, an inter-byte timeout and error reporting.

## Interface
Parameters:
- `N_REGS`, 4: number of configuration registers; indices 0..N_REGS-1.
- `VAL_BYTES`, 1: bytes per register value (1..4); register width REG_W = 8*VAL_BYTES.
- `ESC_CHAR`, 8'h1B: escape introducer byte.
- `TIMEOUT_CYC`, 5_000_000: idle clock cycles allowed inside a sequence before abort (100 ms at 50 MHz); 0 disables the timeout.
- `RESET_VALS`, {..., 8'hA0, 8'h80}: N_REGS*REG_W concatenated reset values; index 0 occupies the LSBs.

Ports:
- `CLK_50MHz`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data`  in  8  received byte; valid only when `data_en` is high.
- `data_en`  in  1  single-cycle strobe from the UART receiver.
- `fwd_data`  out  8  forwarded display byte; holds its last value between strobes.
- `fwd_en`  out  1  one-cycle strobe qualifying `fwd_data`.
- `cfg_regs`  out  N_REGS*REG_W  configuration register bank; index 0 in the LSBs.
- `cfg_update`  out  N_REGS  one-cycle pulse per register, asserted on the cycle its new value appears.
- `err`  out  1  one-cycle pulse on a bad index or a timeout.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, CMD, VAL.
- IDLE:
  - A byte other than ESC_CHAR is forwarded: `fwd_en` asserts, FSM stays in IDLE.
  - ESC_CHAR is not forwarded; FSM goes to CMD.
- CMD:
  - ESC_CHAR: forward the literal ESC_CHAR, go to IDLE.
  - Byte < N_REGS: latch it as the index, clear the byte counter, go to VAL.
  - Byte ≥ N_REGS: pulse `err`, go to IDLE; nothing is written or forwarded.
- VAL:
  - Accept VAL_BYTES bytes, least-significant byte first, into a shadow register.
  - On the last byte, write the shadow register to `cfg_regs[idx]`, pulse `cfg_update[idx]`, go to IDLE.
  - Partial values never appear on `cfg_regs`.
  - In VAL, ESC_CHAR is ordinary data and is not special.
- Timeout:
  - The counter clears on every `data_en` and counts while the FSM is in CMD or VAL.
  - When it reaches TIMEOUT_CYC: pulse `err`, go to IDLE, discard the shadow register.
  - If `data_en` arrives on the same cycle the timeout is reached, the byte wins: it is consumed normally and there is no `err`.
- Reset (asserted at any time, including mid-sequence): FSM to IDLE, `cfg_regs` = RESET_VALS, all strobes 0, `fwd_data` = 8'h00, counters 0.
- Unused high bits of the index byte are still compared, so index 8'h84 with N_REGS=4 is an error.

## Timing
- Every output is registered. Latency from `data_en` to `fwd_en`, `cfg_update` or `err` is 1 cycle.
- `cfg_regs` changes on the same edge that raises `cfg_update`.
- Back-to-back `data_en` on consecutive cycles is supported; no bytes are dropped and there is no backpressure.
- At most one of `fwd_en`, `err`, or any `cfg_update` bit is high on any cycle, and at most one `cfg_update` bit is high at a time.
- `busy` is high from the cycle after ESC is accepted until the cycle after the sequence ends.
- A timeout `err` asserts exactly TIMEOUT_CYC+1 cycles after the last accepted byte.

## Structure
- Package `uart_esc_pkg` holds:
  - the state enum (IDLE/CMD/VAL, 2-bit encoding);
  - the default ESC value;
  - the default reset-value constant for rows 8'h80 and columns 8'hA0.
- Sub-module `esc_timeout`: parametrised down-counter with `clear`, `run` and a one-cycle `expired` output. The counter width is $clog2(TIMEOUT_CYC+1). The whole sub-module is tied off when TIMEOUT_CYC=0.
- Top level: FSM, shadow register, register bank, forward register.

## Test plan
- Defaults; bytes 0x41, 0x42 → `fwd_en` twice with 0x41 then 0x42, each 1 cycle after its strobe; `cfg_regs` stays {…A0,80}.
- ESC,0x01,0x64 → `cfg_regs[1]`=0x64; `cfg_update`=4'b0010 for 1 cycle; no `fwd_en` on any of the three bytes.
- VAL_BYTES=2: ESC,0x02,0x34,0x12 → `cfg_regs[2]`=0x1234, updated only after the 4th byte.
- ESC,ESC → a single `fwd_en` with 0x1B. ESC,0x07 with N_REGS=4 → `err` pulse; a following 0x41 is forwarded.
- TIMEOUT_CYC=100: ESC,0x00, then silence → `err` at 101 cycles; then 0x55 is forwarded and reg0 is unchanged. Repeat with the byte landing on the expiry cycle → the byte is accepted and there is no `err`.
- Assert `reset` between the value bytes of a 2-byte write → regs return to RESET_VALS, FSM to IDLE, next 0x41 is forwarded.

Source files
------------

// File: rtl/uart_esc_pkg.sv
// Shared types and default constants for the UART escape-sequence decoder.
package uart_esc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    VAL  = 2'd2
  } esc_state_e;

  localparam logic [7:0]  ESC_DEFAULT        = 8'h1B;
  localparam logic [7:0]  DEFAULT_ROWS       = 8'h80;
  localparam logic [7:0]  DEFAULT_COLS       = 8'hA0;
  // Register 0 = rows, register 1 = columns, remaining registers reset to zero.
  localparam logic [15:0] DEFAULT_RESET_VALS = {DEFAULT_COLS, DEFAULT_ROWS};

endpackage

// File: rtl/esc_timeout.sv
// Inter-byte watchdog: reloads on clear, counts down while run is high and
// raises expired for the cycle in which the count would reach zero.
module esc_timeout #(
  parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_tie;
      assign unused_tie = clk ^ rst ^ clear ^ run;
      assign expired    = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYC + 1);
      localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC);

      logic [CW-1:0] cnt_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else if (clear) begin
          cnt_q <= LOAD;
        end else if (run && (cnt_q != '0)) begin
          cnt_q <= cnt_q - CW'(1);
        end
      end

      // A byte arriving on the expiry cycle takes priority over the abort.
      assign expired = run && !clear && (cnt_q == CW'(1));
    end
  endgenerate

endmodule

// File: rtl/uart_escape_decoder.sv
// Splits the UART byte stream into forwarded display bytes and ESC-prefixed
// register writes into a configuration bank.
module uart_escape_decoder
  import uart_esc_pkg::*;
#(
  parameter int                                N_REGS      = 4,
  parameter int                                VAL_BYTES   = 1,
  parameter logic [7:0]                        ESC_CHAR    = ESC_DEFAULT,
  parameter int unsigned                       TIMEOUT_CYC = 5_000_000,
  parameter logic [N_REGS*8*VAL_BYTES-1:0]     RESET_VALS  =
      (N_REGS*8*VAL_BYTES)'(DEFAULT_RESET_VALS)
) (
  input  logic                            CLK_50MHz,
  input  logic                            reset,
  input  logic [7:0]                      data,
  input  logic                            data_en,
  output logic [7:0]                      fwd_data,
  output logic                            fwd_en,
  output logic [N_REGS*8*VAL_BYTES-1:0]   cfg_regs,
  output logic [N_REGS-1:0]               cfg_update,
  output logic                            err,
  output logic                            busy
);

  localparam int REG_W = 8 * VAL_BYTES;
  localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int BC_W  = (VAL_BYTES > 1) ? $clog2(VAL_BYTES) : 1;
  localparam logic [8:0]      N_REGS_B  = 9'(N_REGS);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(VAL_BYTES - 1);

  esc_state_e        state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [BC_W-1:0]   cnt_q;
  logic [REG_W-1:0]  shadow_q;
  logic [REG_W-1:0]  val_d;
  logic [7:0]        fwd_data_q;
  logic              fwd_en_q;
  logic [N_REGS-1:0] upd_q;
  logic              err_q;
  logic              idx_ok;
  logic              wr_en;
  logic              tmo_expired;

  // The full byte is compared, so stray high bits make an index invalid.
  assign idx_ok = ({1'b0, data} < N_REGS_B);
  assign wr_en  = data_en && (state_q == VAL) && (cnt_q == LAST_BYTE);

  always_comb begin
    val_d = shadow_q;
    val_d[REG_W-8 +: 8] = data;
  end

  esc_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (CLK_50MHz),
    .rst     (reset),
    .clear   (data_en),
    .run     (state_q != IDLE),
    .expired (tmo_expired)
  );

  always_ff @(posedge CLK_50MHz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      fwd_data_q <= 8'h00;
      fwd_en_q   <= 1'b0;
      upd_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      fwd_en_q <= 1'b0;
      upd_q    <= '0;
      err_q    <= 1'b0;
      if (data_en) begin
        case (state_q)
          IDLE: begin
            if (data == ESC_CHAR) begin
              state_q <= CMD;
            end else begin
              fwd_data_q <= data;
              fwd_en_q   <= 1'b1;
            end
          end
          CMD: begin
            if (data == ESC_CHAR) begin
              fwd_data_q <= data;
              fwd_en_q   <= 1'b1;
              state_q    <= IDLE;
            end else if (idx_ok) begin
              idx_q    <= data[IDX_W-1:0];
              cnt_q    <= '0;
              shadow_q <= '0;
              state_q  <= VAL;
            end else begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
          VAL: begin
            if (cnt_q == LAST_BYTE) begin
              upd_q   <= N_REGS'(1) << idx_q;
              state_q <= IDLE;
            end else begin
              shadow_q[8*cnt_q +: 8] <= data;
              cnt_q                  <= cnt_q + BC_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (tmo_expired) begin
        err_q    <= 1'b1;
        shadow_q <= '0;
        state_q  <= IDLE;
      end
    end
  end

  // Each register only ever loads a complete value assembled in the shadow.
  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_bank
      logic [REG_W-1:0] reg_q;

      always_ff @(posedge CLK_50MHz or posedge reset) begin
        if (reset) begin
          reg_q <= RESET_VALS[gi*REG_W +: REG_W];
        end else if (wr_en && (idx_q == IDX_W'(gi))) begin
          reg_q <= val_d;
        end
      end

      assign cfg_regs[gi*REG_W +: REG_W] = reg_q;
    end
  endgenerate

  assign fwd_data   = fwd_data_q;
  assign fwd_en     = fwd_en_q;
  assign cfg_update = upd_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_escape_decoder.sv
// Scoreboard bench: two decoder instances (1-byte and 2-byte values) driven by
// directed byte sequences; a monitor pops expected responses as outputs appear.
module tb_uart_escape_decoder;

  localparam logic [7:0]  ESC    = 8'h1B;
  localparam logic [63:0] RST_B  = 64'h0000_0000_00A0_0080;

  typedef struct {
    int          kind;   // 0 forward, 1 register write, 2 error
    logic [7:0]  b;
    int          idx;
    logic [15:0] val;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];

  logic        rst_a, den_a, fwd_en_a, err_a, busy_a;
  logic [7:0]  data_a, fwd_data_a;
  logic [31:0] regs_a;
  logic [3:0]  upd_a;
  logic        rst_b, den_b, fwd_en_b, err_b, busy_b;
  logic [7:0]  data_b, fwd_data_b;
  logic [63:0] regs_b;
  logic [3:0]  upd_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_escape_decoder #(
    .N_REGS(4), .VAL_BYTES(1), .TIMEOUT_CYC(100)
  ) dut_a (
    .CLK_50MHz(clk), .reset(rst_a), .data(data_a), .data_en(den_a),
    .fwd_data(fwd_data_a), .fwd_en(fwd_en_a), .cfg_regs(regs_a),
    .cfg_update(upd_a), .err(err_a), .busy(busy_a)
  );

  uart_escape_decoder #(
    .N_REGS(4), .VAL_BYTES(2), .TIMEOUT_CYC(100), .RESET_VALS(RST_B)
  ) dut_b (
    .CLK_50MHz(clk), .reset(rst_b), .data(data_b), .data_en(den_b),
    .fwd_data(fwd_data_b), .fwd_en(fwd_en_b), .cfg_regs(regs_b),
    .cfg_update(upd_b), .err(err_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, got, expv);
    end else begin
      $display("ok   %s @cyc %0d: 0x%0h", name, cyc, got);
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic exp_fwd(input int d, input logic [7:0] b);
    exp_t e;
    e.kind = 0; e.b = b; e.idx = 0; e.val = '0; e.cyc = cyc + 1;
    push(d, e);
  endtask

  task automatic exp_cfg(input int d, input int idx, input logic [15:0] val);
    exp_t e;
    e.kind = 1; e.b = '0; e.idx = idx; e.val = val; e.cyc = cyc + 1;
    push(d, e);
  endtask

  task automatic exp_err(input int d, input int at);
    exp_t e;
    e.kind = 2; e.b = '0; e.idx = 0; e.val = '0; e.cyc = at;
    push(d, e);
  endtask

  // Called at a falling edge; the byte is sampled on the next rising edge.
  task automatic send(input int d, input logic [7:0] b);
    if (d == 0) begin data_a = b; den_a = 1'b1; end
    else        begin data_b = b; den_b = 1'b1; end
    @(negedge clk);
    den_a = 1'b0;
    den_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_out(input int d, input logic fe, input logic [7:0] fd,
                           input logic er, input logic [3:0] upd,
                           input logic [63:0] regs, input logic rst);
    exp_t        e;
    int          rw;
    logic [63:0] mask;
    string       tag;
    tag = (d == 0) ? "a" : "b";
    rw  = (d == 0) ? 8 : 16;
    if (!rst && (fe || er || (|upd))) begin
      if (((d == 0) ? qa.size() : qb.size()) == 0) begin
        chk($sformatf("unexpected_out_%s", tag), {58'h0, fe, er, upd}, 64'h0);
      end else begin
        e = (d == 0) ? qa.pop_front() : qb.pop_front();
        chk($sformatf("latency_%s", tag), 64'(cyc), 64'(e.cyc));
        case (e.kind)
          0: begin
            chk($sformatf("fwd_strobes_%s", tag), {58'h0, fe, er, upd}, 64'h20);
            chk($sformatf("fwd_data_%s", tag), {56'h0, fd}, {56'h0, e.b});
          end
          1: begin
            mask = (64'h1 << rw) - 64'h1;
            chk($sformatf("cfg_strobes_%s", tag), {58'h0, fe, er, upd},
                {58'h0, 2'b00, 4'(4'b0001 << e.idx)});
            chk($sformatf("cfg_reg%0d_%s", e.idx, tag), (regs >> (e.idx * rw)) & mask,
                {48'h0, e.val});
          end
          default: begin
            chk($sformatf("err_strobes_%s", tag), {58'h0, fe, er, upd}, 64'h10);
          end
        endcase
      end
    end
  endtask

  task automatic stimulus();
    int c;
    idle(3);
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle(1);
    chk("reset_regs_a", {32'h0, regs_a}, 64'h0000_A080);
    chk("reset_regs_b", regs_b, RST_B);
    chk("reset_outs_a", {54'h0, fwd_data_a, fwd_en_a, busy_a}, 64'h0);

    // Plain bytes, back to back
    exp_fwd(0, 8'h41); send(0, 8'h41);
    exp_fwd(0, 8'h42); send(0, 8'h42);
    idle(3);
    chk("regs_after_fwd_a", {32'h0, regs_a}, 64'h0000_A080);

    // Single-byte register write
    send(0, ESC);
    chk("busy_after_esc_a", {63'h0, busy_a}, 64'h1);
    send(0, 8'h01);
    exp_cfg(0, 1, 16'h0064); send(0, 8'h64);
    chk("busy_after_write_a", {63'h0, busy_a}, 64'h0);
    idle(2);
    chk("regs_after_write_a", {32'h0, regs_a}, 64'h0000_6480);

    // Escaped literal ESC, bad indices, recovery
    send(0, ESC); exp_fwd(0, ESC); send(0, ESC);
    send(0, ESC); exp_err(0, cyc + 1); send(0, 8'h07);
    exp_fwd(0, 8'h41); send(0, 8'h41);
    send(0, ESC); exp_err(0, cyc + 1); send(0, 8'h84);
    idle(3);

    // Timeout after the index byte
    send(0, ESC);
    c = cyc;
    exp_err(0, c + 101);
    send(0, 8'h00);
    idle(110);
    chk("busy_after_timeout_a", {63'h0, busy_a}, 64'h0);
    exp_fwd(0, 8'h55); send(0, 8'h55);
    idle(2);
    chk("regs_after_timeout_a", {32'h0, regs_a}, 64'h0000_6480);

    // Byte landing on the expiry cycle wins
    send(0, ESC);
    c = cyc;
    send(0, 8'h00);
    while (cyc < c + 100) @(negedge clk);
    exp_cfg(0, 0, 16'h0077); send(0, 8'h77);
    idle(110);
    chk("regs_after_race_a", {32'h0, regs_a}, 64'h0000_6477);

    // Two-byte value, LSB first, no partial update
    send(1, ESC); send(1, 8'h02); send(1, 8'h34);
    chk("regs_partial_b", regs_b, RST_B);
    exp_cfg(1, 2, 16'h1234); send(1, 8'h12);
    idle(2);
    chk("regs_after_write_b", regs_b, 64'h0000_1234_00A0_0080);

    // ESC inside a value is plain data
    send(1, ESC); send(1, 8'h01); send(1, ESC);
    exp_cfg(1, 1, 16'h1B1B); send(1, ESC);
    idle(2);
    chk("regs_esc_value_b", regs_b, 64'h0000_1234_1B1B_0080);

    // Reset between value bytes
    send(1, ESC); send(1, 8'h02); send(1, 8'h34);
    rst_b = 1'b1;
    idle(2);
    chk("regs_mid_reset_b", regs_b, RST_B);
    chk("busy_mid_reset_b", {63'h0, busy_b}, 64'h0);
    rst_b = 1'b0;
    idle(1);
    exp_fwd(1, 8'h41); send(1, 8'h41);
    idle(3);
    chk("regs_after_reset_b", regs_b, RST_B);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    den_a = 1'b0; den_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00;
    @(negedge clk);
    fork
      begin
        forever begin
          @(negedge clk);
          check_out(0, fwd_en_a, fwd_data_a, err_a, upd_a, {32'h0, regs_a}, rst_a);
          check_out(1, fwd_en_b, fwd_data_b, err_b, upd_b, regs_b, rst_b);
        end
      end
      stimulus();
    join_any
    disable fork;
    chk("pending_a", 64'(qa.size()), 64'h0);
    chk("pending_b", 64'(qb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
